cpu_run_controller: RTL and testbench



---
 rtl/cpu_run_controller_pkg.sv | 26 ++
 rtl/cpu_run_controller_bp_match.sv | 42 ++++
 rtl/cpu_run_controller.sv | 161 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_controller_pkg.sv
// ============================================================================
// Module   : cpu_run_controller_pkg
// Purpose  : Command and run-state encodings shared by the run controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_run_controller_pkg;

    localparam logic [2:0] CMD_STOP       = 3'd0;
    localparam logic [2:0] CMD_STEP_CYCLE = 3'd1;
    localparam logic [2:0] CMD_STEP_INSTR = 3'd2;
    localparam logic [2:0] CMD_RUN        = 3'd3;
    localparam logic [2:0] CMD_RUN_N      = 3'd4;

    typedef enum logic [2:0] {
        ST_HALTED   = 3'd0,
        ST_STEP_CYC = 3'd1,
        ST_STEP_INS = 3'd2,
        ST_RUN      = 3'd3,
        ST_RUN_N    = 3'd4
    } run_state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_run_controller_bp_match.sv
// ============================================================================
// Module   : bp_match
// Purpose  : PC breakpoint comparator array with lowest-index priority encode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_match #(
    parameter int PC_WIDTH = 32,
    parameter int NUM_BP   = 2
) (
    input  logic [NUM_BP*PC_WIDTH-1:0] bpAddr,
    input  logic [NUM_BP-1:0]          bpEnable,
    input  logic [PC_WIDTH-1:0]        pcIn,
    output logic                       anyHit,
    output logic [2:0]                 hitIndex
);

    logic [NUM_BP-1:0] w_match;

    generate
        for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_cmp
            assign w_match[gi] = bpEnable[gi] &&
                                 (bpAddr[gi*PC_WIDTH +: PC_WIDTH] == pcIn);
        end
    endgenerate

    assign anyHit = |w_match;

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        hitIndex = 3'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hitIndex = 3'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_run_controller.sv
// ============================================================================
// Module   : cpu_run_controller
// Purpose  : Clock-enable run controller: halt, step, run, run-N, breakpoints.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int STATE_WIDTH = 4,
    parameter int FETCH_STATE = 0,
    parameter int CNT_WIDTH   = 16,
    parameter int NUM_BP      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmdValid,
    input  logic [2:0]                 cmd,
    input  logic [CNT_WIDTH-1:0]       runCount,
    input  logic [NUM_BP*PC_WIDTH-1:0] bpAddr,
    input  logic [NUM_BP-1:0]          bpEnable,
    input  logic [PC_WIDTH-1:0]        pcIn,
    input  logic [STATE_WIDTH-1:0]     cpuState,
    output logic                       cpuEn,
    output logic                       halted,
    output logic                       bpHit,
    output logic [2:0]                 bpIndex,
    output logic [CNT_WIDTH-1:0]       cycleCount
);

    run_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] remain_q, remain_d;
    logic                 started_q, started_d;
    logic                 bpHit_q, bpHit_d;
    logic [2:0]           bpIndex_q, bpIndex_d;
    logic [CNT_WIDTH-1:0] cycleCount_q, cycleCount_d;

    logic       w_anyHit;
    logic [2:0] w_hitIndex;
    logic       w_atFetch;
    logic       w_bpStop;
    logic       w_stopNow;
    logic       w_stopCmd;
    logic       w_startCmd;

    bp_match #(
        .PC_WIDTH (PC_WIDTH),
        .NUM_BP   (NUM_BP)
    ) u_bp_match (
        .bpAddr   (bpAddr),
        .bpEnable (bpEnable),
        .pcIn     (pcIn),
        .anyHit   (w_anyHit),
        .hitIndex (w_hitIndex)
    );

    // The first enabled cycle after a resume never checks, so a halt at a
    // breakpoint PC does not immediately re-trigger.
    assign w_atFetch  = started_q && (cpuState == STATE_WIDTH'(FETCH_STATE));
    assign w_bpStop   = w_atFetch && w_anyHit;
    assign w_stopNow  = w_atFetch && ((state_q == ST_STEP_INS) || w_anyHit);
    assign w_stopCmd  = cmdValid && (cmd == CMD_STOP);
    assign w_startCmd = cmdValid && (cmd >= CMD_STEP_CYCLE) && (cmd <= CMD_RUN_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HALTED;
            remain_q     <= '0;
            started_q    <= 1'b0;
            bpHit_q      <= 1'b0;
            bpIndex_q    <= 3'd0;
            cycleCount_q <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            started_q    <= started_d;
            bpHit_q      <= bpHit_d;
            bpIndex_q    <= bpIndex_d;
            cycleCount_q <= cycleCount_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        started_d    = started_q | cpuEn;
        bpHit_d      = bpHit_q;
        bpIndex_d    = bpIndex_q;
        cycleCount_d = cycleCount_q + {{(CNT_WIDTH-1){1'b0}}, cpuEn};

        if ((state_q == ST_RUN_N) && cpuEn) begin
            remain_d = remain_q - CNT_WIDTH'(1);
        end

        if (w_stopCmd) begin
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_HALTED: begin
                    if (w_startCmd) begin
                        started_d = 1'b0;
                        bpHit_d   = 1'b0;
                        bpIndex_d = 3'd0;
                        case (cmd)
                            CMD_STEP_CYCLE: state_d = ST_STEP_CYC;
                            CMD_STEP_INSTR: state_d = ST_STEP_INS;
                            CMD_RUN:        state_d = ST_RUN;
                            default: begin
                                state_d  = ST_RUN_N;
                                remain_d = runCount;
                            end
                        endcase
                    end
                end
                ST_STEP_CYC: begin
                    state_d = ST_HALTED;
                end
                ST_STEP_INS, ST_RUN: begin
                    if (w_stopNow) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_RUN_N: begin
                    if ((remain_q == '0) || w_bpStop) begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                    state_d = ST_HALTED;
                end
            endcase

            if ((state_q != ST_HALTED) && (state_q != ST_STEP_CYC) && w_bpStop) begin
                bpHit_d   = 1'b1;
                bpIndex_d = w_hitIndex;
            end
        end
    end

    always_comb begin
        cpuEn = 1'b0;
        if (!rst && !w_stopCmd) begin
            case (state_q)
                ST_STEP_CYC:         cpuEn = 1'b1;
                ST_STEP_INS, ST_RUN: cpuEn = !w_stopNow;
                ST_RUN_N:            cpuEn = (remain_q != '0) && !w_bpStop;
                default:             cpuEn = 1'b0;
            endcase
        end
    end

    assign halted     = (state_q == ST_HALTED);
    assign bpHit      = bpHit_q;
    assign bpIndex    = bpIndex_q;
    assign cycleCount = cycleCount_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
// ============================================================================
// Module   : tb_cpu_run_controller
// Purpose  : Directed plus randomized check of cpu_run_controller against a
//            behavioural model and a toy 4-state CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_controller;

    localparam int PC_WIDTH    = 32;
    localparam int STATE_WIDTH = 4;
    localparam int CNT_WIDTH   = 16;
    localparam int NUM_BP      = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       cmdValid;
    logic [2:0]                 cmd;
    logic [CNT_WIDTH-1:0]       runCount;
    logic [NUM_BP*PC_WIDTH-1:0] bpAddr;
    logic [NUM_BP-1:0]          bpEnable;
    logic [PC_WIDTH-1:0]        pcIn;
    logic [STATE_WIDTH-1:0]     cpuState;
    logic                       cpuEn;
    logic                       halted;
    logic                       bpHit;
    logic [2:0]                 bpIndex;
    logic [CNT_WIDTH-1:0]       cycleCount;

    cpu_run_controller #(
        .PC_WIDTH    (PC_WIDTH),
        .STATE_WIDTH (STATE_WIDTH),
        .FETCH_STATE (0),
        .CNT_WIDTH   (CNT_WIDTH),
        .NUM_BP      (NUM_BP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmdValid   (cmdValid),
        .cmd        (cmd),
        .runCount   (runCount),
        .bpAddr     (bpAddr),
        .bpEnable   (bpEnable),
        .pcIn       (pcIn),
        .cpuState   (cpuState),
        .cpuEn      (cpuEn),
        .halted     (halted),
        .bpHit      (bpHit),
        .bpIndex    (bpIndex),
        .cycleCount (cycleCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 idle, 1 one cycle, 2 one instruction, 3 free, 4 budgeted.
    int m_mode    = 0;
    bit m_started = 0;
    int m_left    = 0;
    bit m_bp      = 0;
    int m_bpi     = 0;
    int m_cnt     = 0;
    int n_mode, n_left, n_bpi, n_cnt;
    bit n_started, n_bp;
    bit e_en;

    // Toy CPU: four states per instruction, PC steps by 4 at fetch, 64-byte loop.
    int  cpu_st = 0;
    int  cpu_pc = 0;
    bit  en_s;

    assign cpuState = STATE_WIDTH'(cpu_st);
    assign pcIn     = PC_WIDTH'(cpu_pc);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit stop, bpany, at_fetch, bpstop;
        int bpi;
        stop  = cmdValid && (cmd == 3'd0);
        bpany = 0;
        bpi   = 0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bpEnable[i] && (bpAddr[i*PC_WIDTH +: PC_WIDTH] == pcIn)) begin
                bpany = 1;
                bpi   = i;
            end
        end
        at_fetch = m_started && (cpu_st == 0);
        bpstop   = at_fetch && bpany;

        if (rst || stop)      e_en = 0;
        else if (m_mode == 1) e_en = 1;
        else if (m_mode == 2) e_en = !at_fetch;
        else if (m_mode == 3) e_en = !bpstop;
        else if (m_mode == 4) e_en = (m_left != 0) && !bpstop;
        else                  e_en = 0;

        n_mode = m_mode; n_started = m_started; n_left = m_left;
        n_bp = m_bp; n_bpi = m_bpi; n_cnt = m_cnt;
        if (rst) begin
            n_mode = 0; n_started = 0; n_left = 0; n_bp = 0; n_bpi = 0; n_cnt = 0;
        end else begin
            if (e_en) begin
                n_cnt = (m_cnt + 1) % 65536;
                n_started = 1;
                if (m_mode == 4) n_left = m_left - 1;
            end
            if (stop) begin
                n_mode = 0;
            end else if (m_mode == 0) begin
                if (cmdValid && cmd >= 1 && cmd <= 4) begin
                    n_mode = int'(cmd); n_started = 0; n_bp = 0; n_bpi = 0;
                    if (cmd == 3'd4) n_left = int'(runCount);
                end
            end else if (m_mode == 1) begin
                n_mode = 0;
            end else if ((m_mode == 2 && at_fetch) || (m_mode == 3 && bpstop) ||
                         (m_mode == 4 && (m_left == 0 || bpstop))) begin
                n_mode = 0;
                if (bpstop) begin
                    n_bp = 1; n_bpi = bpi;
                end
            end
        end
    endtask

    // One clock cycle: compare at the falling edge, advance model after the rise.
    task automatic tick();
        @(negedge clk);
        model_eval();
        chk("cpuEn", int'(cpuEn), int'(e_en));
        chk("halted", int'(halted), int'(m_mode == 0));
        chk("bpHit", int'(bpHit), int'(m_bp));
        chk("bpIndex", int'(bpIndex), m_bpi);
        chk("cycleCount", int'(cycleCount), m_cnt);
        en_s = cpuEn;
        @(posedge clk);
        #1;
        m_mode = n_mode; m_started = n_started; m_left = n_left;
        m_bp = n_bp; m_bpi = n_bpi; m_cnt = n_cnt;
        if (en_s) begin
            if (cpu_st == 0) cpu_pc = (cpu_pc + 4) & 'h3F;
            cpu_st = (cpu_st + 1) % 4;
        end
    endtask

    task automatic strobe(input logic [2:0] c, input int rc);
        cmdValid = 1'b1; cmd = c; runCount = CNT_WIDTH'(rc);
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic run_until_halt(input int limit);
        for (int k = 0; k < limit; k++) begin
            tick();
            if (halted) break;
        end
    endtask

    initial begin
        rst = 1'b1; cmdValid = 1'b0; cmd = 3'd0; runCount = '0;
        bpAddr = '0; bpEnable = '0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();
        chk("reset_halted", int'(halted), 1);
        chk("reset_count", int'(cycleCount), 0);
        chk("reset_bphit", int'(bpHit), 0);
        chk("reset_en", int'(cpuEn), 0);

        for (int s = 0; s < 3; s++) begin
            strobe(3'd1, 0);
            tick();
            chk("stepcyc_halted", int'(halted), 1);
        end
        chk("stepcyc_count3", int'(cycleCount), 3);

        strobe(3'd1, 0);
        tick();
        chk("fetch_align_pc", cpu_pc, 4);
        strobe(3'd2, 0);
        run_until_halt(10);
        chk("stepins_count", int'(cycleCount), 8);
        chk("stepins_pc", cpu_pc, 8);
        chk("stepins_state", cpu_st, 0);

        strobe(3'd4, 10);
        run_until_halt(20);
        chk("runn10_count", int'(cycleCount), 18);
        chk("runn10_halted", int'(halted), 1);
        strobe(3'd4, 0);
        tick();
        chk("runn0_halted", int'(halted), 1);
        chk("runn0_count", int'(cycleCount), 18);

        bpAddr = {32'h0, 32'h10}; bpEnable = 2'b01;
        strobe(3'd3, 0);
        run_until_halt(200);
        chk("bp10_halted", int'(halted), 1);
        chk("bp10_pc", cpu_pc, 'h10);
        chk("bp10_state", cpu_st, 0);
        chk("bp10_hit", int'(bpHit), 1);
        chk("bp10_index", int'(bpIndex), 0);
        strobe(3'd3, 0);
        tick();
        chk("resume_hit_clear", int'(bpHit), 0);
        chk("resume_pc", cpu_pc, 'h14);
        strobe(3'd0, 0);

        bpAddr = {32'h20, 32'h20}; bpEnable = 2'b11;
        strobe(3'd3, 0);
        run_until_halt(200);
        chk("bp20_pc", cpu_pc, 'h20);
        chk("bp20_hit", int'(bpHit), 1);
        chk("bp20_index", int'(bpIndex), 0);

        bpAddr = {32'h30, 32'h30};
        strobe(3'd3, 0);
        for (int k = 0; k < 200; k++) begin
            if (cpu_st == 0 && cpu_pc == 'h30 && m_started) begin
                cmdValid = 1'b1; cmd = 3'd0;
            end
            tick();
            cmdValid = 1'b0;
            if (halted) break;
        end
        chk("stopwins_halted", int'(halted), 1);
        chk("stopwins_hit", int'(bpHit), 0);
        chk("stopwins_pc", cpu_pc, 'h30);

        bpAddr = {32'h0, 32'h4}; bpEnable = 2'b10;
        strobe(3'd3, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_halted", int'(halted), 1);
        chk("rst_count", int'(cycleCount), 0);
        tick();

        for (int c = 0; c < 4000; c++) begin
            cmdValid = ($urandom_range(0, 5) == 0);
            cmd      = 3'($urandom_range(0, 7));
            runCount = CNT_WIDTH'($urandom_range(0, 12));
            rst      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) begin
                bpAddr   = {PC_WIDTH'($urandom_range(0, 15) * 4), PC_WIDTH'($urandom_range(0, 15) * 4)};
                bpEnable = NUM_BP'($urandom_range(0, 3));
            end
            tick();
        end
        rst = 1'b0; cmdValid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
